// File: rtl/monitor_scheduler.sv
// Raster timing and overlay sequencing for the dashboard monitor: counters, sync,
// ROM addresses, a ROM-latency-aligned source select, and frame-safe value capture.
module monitor_scheduler #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DIG_X0   = 224,
    parameter int DIG_Y0   = 208,
    parameter int ICON_X0  = 0,
    parameter int ICON_Y0  = 0
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        upd_req,
    input  logic [3:0]  a_in,
    input  logic [3:0]  b_in,
    input  logic [3:0]  c_in,
    input  logic [1:0]  drive_in,
    output logic        upd_ack,
    output logic [16:0] pixel_addr,
    output logic [16:0] pixel_addr_num,
    output logic [3:0]  src_sel,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [9:0]  h_cnt,
    output logic [9:0]  v_cnt
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] DX0      = 10'(DIG_X0);
    localparam logic [9:0] DY0      = 10'(DIG_Y0);
    localparam logic [9:0] IX0      = 10'(ICON_X0);
    localparam logic [9:0] IY0      = 10'(ICON_Y0);

    typedef enum logic {ST_IDLE, ST_PEND} state_t;

    logic [9:0]  r_hc, r_vc;
    logic [3:0]  r_dig [3];
    logic [1:0]  r_gear;
    state_t      r_state;
    logic        r_upd_ack;

    logic [16:0] r_addr, r_addr_num;
    logic [3:0]  r_sel1;
    logic [9:0]  r_h1, r_v1;
    logic        r_hs1, r_vs1, r_vld1;

    logic [3:0]  r_src_sel;
    logic [9:0]  r_h_cnt, r_v_cnt;
    logic        r_hsync, r_vsync, r_valid;

    logic [9:0]  w_dig_dx, w_dig_dy, w_icon_dx, w_icon_dy;
    logic        w_in_dig, w_in_icon;
    logic        w_hs_n, w_vs_n, w_vis;
    logic [3:0]  w_dig_code [4];
    logic [3:0]  w_gear_code, w_sel1;
    logic        w_cap_point, w_capture;

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    // Unsigned wrap makes positions left of / above a region look huge, so one compare bounds each axis.
    assign w_dig_dx  = r_hc - DX0;
    assign w_dig_dy  = r_vc - DY0;
    assign w_icon_dx = r_hc - IX0;
    assign w_icon_dy = r_vc - IY0;
    assign w_in_dig  = (w_dig_dx < 10'd192) && (w_dig_dy < 10'd64);
    assign w_in_icon = (w_icon_dx < 10'd64) && (w_icon_dy < 10'd64);

    assign w_hs_n = !((r_hc >= HS_FIRST) && (r_hc <= HS_LAST));
    assign w_vs_n = !((r_vc >= VS_FIRST) && (r_vc <= VS_LAST));
    assign w_vis  = (r_hc < H_ACT) && (r_vc < V_ACT);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dig_code
            assign w_dig_code[gi] = (r_dig[gi] > 4'd9) ? 4'd0 : r_dig[gi];
        end
    endgenerate
    assign w_dig_code[3] = 4'd0;

    always_comb begin
        case (r_gear)
            2'b01:   w_gear_code = 4'd12;
            2'b10:   w_gear_code = 4'd10;
            default: w_gear_code = 4'd11;
        endcase
    end

    always_comb begin
        w_sel1 = 4'd15;
        if (w_in_dig) begin
            w_sel1 = w_dig_code[w_dig_dx[7:6]];
        end else if (w_in_icon) begin
            w_sel1 = w_gear_code;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_addr     <= '0;
            r_addr_num <= '0;
            r_sel1     <= 4'd15;
            r_h1       <= '0;
            r_v1       <= '0;
            r_hs1      <= 1'b1;
            r_vs1      <= 1'b1;
            r_vld1     <= 1'b0;
        end else begin
            r_addr     <= w_in_icon ? {5'd0, w_icon_dy[5:0], w_icon_dx[5:0]} : '0;
            r_addr_num <= w_in_dig ? {5'd0, w_dig_dy[5:0], w_dig_dx[5:0]} : '0;
            r_sel1     <= w_sel1;
            r_h1       <= r_hc;
            r_v1       <= r_vc;
            r_hs1      <= w_hs_n;
            r_vs1      <= w_vs_n;
            r_vld1     <= w_vis;
        end
    end

    // Second stage lines everything up with the ROM data, which lands one cycle after the address.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_src_sel <= 4'd15;
            r_h_cnt   <= '0;
            r_v_cnt   <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_valid   <= 1'b0;
        end else begin
            r_src_sel <= r_sel1;
            r_h_cnt   <= r_h1;
            r_v_cnt   <= r_v1;
            r_hsync   <= r_hs1;
            r_vsync   <= r_vs1;
            r_valid   <= r_vld1;
        end
    end

    // Values change only on the first blanking line so a frame never mixes old and new.
    assign w_cap_point = (r_hc == 10'd0) && (r_vc == V_ACT);
    assign w_capture   = w_cap_point && ((r_state == ST_PEND) || upd_req);

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_upd_ack <= 1'b0;
            r_dig[0]  <= '0;
            r_dig[1]  <= '0;
            r_dig[2]  <= '0;
            r_gear    <= 2'b00;
        end else begin
            r_upd_ack <= 1'b0;
            if (w_capture) begin
                r_dig[0]  <= a_in;
                r_dig[1]  <= b_in;
                r_dig[2]  <= c_in;
                r_gear    <= drive_in;
                r_upd_ack <= 1'b1;
                r_state   <= ST_IDLE;
            end else if (upd_req) begin
                r_state <= ST_PEND;
            end
        end
    end

    assign upd_ack        = r_upd_ack;
    assign pixel_addr     = r_addr;
    assign pixel_addr_num = r_addr_num;
    assign src_sel        = r_src_sel;
    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign valid          = r_valid;
    assign h_cnt          = r_h_cnt;
    assign v_cnt          = r_v_cnt;

endmodule

// File: tb/tb_monitor_scheduler.sv
// Bench for monitor_scheduler on a shrunken raster so several whole frames fit in a short run;
// every output is compared each cycle against a position/latch model computed from frame arithmetic.
module tb_monitor_scheduler;

    localparam int H_ACTIVE = 257;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 4;
    localparam int H_BP     = 2;
    localparam int V_ACTIVE = 65;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int DIG_X0   = 64;
    localparam int DIG_Y0   = 1;
    localparam int ICON_X0  = 0;
    localparam int ICON_Y0  = 0;
    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FRAME    = HT * VT;
    localparam int CAP      = V_ACTIVE * HT;

    logic        clk_25MHz = 1'b0;
    logic        rst = 1'b1;
    logic        upd_req = 1'b0;
    logic [3:0]  a_in = '0, b_in = '0, c_in = '0;
    logic [1:0]  drive_in = '0;
    logic        upd_ack;
    logic [16:0] pixel_addr, pixel_addr_num;
    logic [3:0]  src_sel;
    logic        hsync, vsync, valid;
    logic [9:0]  h_cnt, v_cnt;

    monitor_scheduler #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .DIG_X0(DIG_X0), .DIG_Y0(DIG_Y0), .ICON_X0(ICON_X0), .ICON_Y0(ICON_Y0)
    ) dut (
        .clk_25MHz(clk_25MHz), .rst(rst), .upd_req(upd_req),
        .a_in(a_in), .b_in(b_in), .c_in(c_in), .drive_in(drive_in),
        .upd_ack(upd_ack), .pixel_addr(pixel_addr), .pixel_addr_num(pixel_addr_num),
        .src_sel(src_sel), .hsync(hsync), .vsync(vsync), .valid(valid),
        .h_cnt(h_cnt), .v_cnt(v_cnt)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    int n_cmp = 0;
    int n_bad = 0;
    int n_ack = 0;
    int m_t = 0;
    bit m_pend = 1'b0;
    bit m_ack = 1'b0;
    int lat_cur[4] = '{default: 0};
    int lat_p1[4]  = '{default: 0};
    int lat_p2[4]  = '{default: 0};

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, m_t);
        end
    endtask

    function automatic bit in_digits(input int h, input int v);
        return (v >= DIG_Y0) && (v < DIG_Y0 + 64) && (h >= DIG_X0) && (h < DIG_X0 + 192);
    endfunction

    function automatic bit in_icon(input int h, input int v);
        return (v >= ICON_Y0) && (v < ICON_Y0 + 64) && (h >= ICON_X0) && (h < ICON_X0 + 64);
    endfunction

    function automatic int exp_sel(input int h, input int v, input int a, input int b,
                                   input int c, input int g);
        int slot, d;
        if (in_digits(h, v)) begin
            slot = (h - DIG_X0) / 64;
            d = (slot == 0) ? a : (slot == 1) ? b : c;
            return (d > 9) ? 0 : d;
        end
        if (in_icon(h, v)) return (g == 1) ? 12 : (g == 2) ? 10 : 11;
        return 15;
    endfunction

    // Model update at the clock edge, using the inputs the DUT samples at that same edge.
    function automatic void model_edge();
        bit at_cap;
        at_cap = ((m_t % FRAME) == CAP);
        lat_p2 = lat_p1;
        lat_p1 = lat_cur;
        if (rst) begin
            m_t = 0;
            lat_cur = '{default: 0};
            m_pend = 1'b0;
            m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            if (at_cap && (m_pend || upd_req)) begin
                lat_cur = '{int'(a_in), int'(b_in), int'(c_in), int'(drive_in)};
                m_ack = 1'b1;
                m_pend = 1'b0;
            end else if (upd_req) begin
                m_pend = 1'b1;
            end
            m_t++;
        end
    endfunction

    task automatic check_outputs();
        int h1, v1, h2, v2;
        int e_sel, e_h, e_v, e_hs, e_vs, e_vld, e_addr, e_num;
        e_sel = 15; e_h = 0; e_v = 0; e_hs = 1; e_vs = 1; e_vld = 0; e_addr = 0; e_num = 0;
        if (m_t >= 2) begin
            h2 = ((m_t - 2) % FRAME) % HT;
            v2 = ((m_t - 2) % FRAME) / HT;
            e_sel = exp_sel(h2, v2, lat_p2[0], lat_p2[1], lat_p2[2], lat_p2[3]);
            e_h = h2;
            e_v = v2;
            e_hs = (h2 >= H_ACTIVE + H_FP && h2 < H_ACTIVE + H_FP + H_SYNC) ? 0 : 1;
            e_vs = (v2 >= V_ACTIVE + V_FP && v2 < V_ACTIVE + V_FP + V_SYNC) ? 0 : 1;
            e_vld = (h2 < H_ACTIVE && v2 < V_ACTIVE) ? 1 : 0;
        end
        if (m_t >= 1) begin
            h1 = ((m_t - 1) % FRAME) % HT;
            v1 = ((m_t - 1) % FRAME) / HT;
            if (in_digits(h1, v1)) e_num = (v1 - DIG_Y0) * 64 + (h1 - DIG_X0) % 64;
            if (in_icon(h1, v1)) e_addr = (v1 - ICON_Y0) * 64 + (h1 - ICON_X0);
        end
        check_val("src_sel", int'(src_sel), e_sel);
        check_val("h_cnt", int'(h_cnt), e_h);
        check_val("v_cnt", int'(v_cnt), e_v);
        check_val("hsync", int'(hsync), e_hs);
        check_val("vsync", int'(vsync), e_vs);
        check_val("valid", int'(valid), e_vld);
        check_val("pixel_addr", int'(pixel_addr), e_addr);
        check_val("pixel_addr_num", int'(pixel_addr_num), e_num);
        check_val("upd_ack", int'(upd_ack), int'(m_ack));
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        model_edge();
        #1;
        check_outputs();
        if (upd_ack) n_ack++;
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (((m_t % FRAME) != target) && (n < 2 * FRAME)) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ack(input string tag, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!upd_ack && (waited < FRAME + 10));
        check_val(tag, int'(upd_ack), 1);
    endtask

    initial begin
        int w;
        repeat (3) tick();
        rst = 1'b0;

        // Request goes pending, then a mid-frame reset hits with the request still held.
        run_until(int'($urandom_range(8, 3)) * HT);
        a_in = 4'd1; b_in = 4'd2; c_in = 4'd3; drive_in = 2'b10;
        upd_req = 1'b1;
        repeat ($urandom_range(600, 100)) tick();
        $display("txn reset_in_pend: rst at cycle %0d row %0d", m_t, (m_t % FRAME) / HT);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_ack("ack_after_rst", w);
        check_val("ack_rst_time", m_t, CAP + 1);
        $display("txn capture a=1 b=2 c=3 gear=D: ack at cycle %0d", m_t);
        wait_ack("ack_sticky", w);
        check_val("ack_period", w, FRAME);
        $display("txn held request recaptured: ack after %0d cycles", w);
        upd_req = 1'b0;

        // Request dropped well before the capture point must still be taken.
        run_until(int'($urandom_range(10, 2)) * HT);
        a_in = 4'(10 + $urandom_range(5, 0));
        b_in = 4'($urandom_range(15, 0));
        c_in = 4'($urandom_range(15, 0));
        drive_in = 2'b01;
        upd_req = 1'b1;
        repeat ($urandom_range(2000, 50)) tick();
        upd_req = 1'b0;
        wait_ack("ack_early", w);
        check_val("ack_early_pos", m_t % FRAME, CAP + 1);
        $display("txn early drop a=%0d b=%0d c=%0d gear=R: ack at cycle %0d", a_in, b_in, c_in, m_t);

        // Request rising exactly on the capture point is taken immediately.
        a_in = 4'($urandom_range(15, 0));
        b_in = 4'($urandom_range(15, 0));
        c_in = 4'($urandom_range(15, 0));
        drive_in = 2'b11;
        run_until(CAP);
        upd_req = 1'b1;
        wait_ack("ack_simul", w);
        check_val("ack_simul_lat", w, 1);
        upd_req = 1'b0;
        $display("txn simultaneous a=%0d b=%0d c=%0d gear=P: ack after %0d cycle", a_in, b_in, c_in, w);
        repeat (3 * HT + 200) tick();

        check_val("ack_total", n_ack, 4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", m_t);
        $fatal(1, "time limit");
    end

endmodule
